// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, opcodes and the EX control bundle.
package mips_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Light instruction decode: control bits, destination register and immediate.
module id_decode
  import mips_pkg::*;
(
  input  logic [DW-1:0] i_instr,
  output logic          o_reg_write,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic [RW-1:0] o_dest,
  output logic [DW-1:0] o_imm
);

  logic [5:0] w_op;
  assign w_op = i_instr[31:26];

  // Control bits and destination; a zero destination never writes.
  always_comb begin
    o_reg_write = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_dest      = '0;
    case (w_op)
      OP_RTYPE: begin
        o_reg_write = 1'b1;
        o_dest      = i_instr[15:11];
      end
      OP_ADDI, OP_SLTI, OP_LUI, OP_ANDI, OP_ORI: begin
        o_reg_write = 1'b1;
        o_dest      = i_instr[20:16];
      end
      OP_LW: begin
        o_reg_write = 1'b1;
        o_mem_read  = 1'b1;
        o_dest      = i_instr[20:16];
      end
      OP_SW: o_mem_write = 1'b1;
      default: ;
    endcase
    if (o_dest == '0) o_reg_write = 1'b0;
  end

  // Logical immediates are zero-extended, everything else sign-extended.
  always_comb begin
    o_imm = {{(DW-16){i_instr[15]}}, i_instr[15:0]};
    if (w_op == OP_ANDI || w_op == OP_ORI) o_imm = {{(DW-16){1'b0}}, i_instr[15:0]};
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with write-back bypass, load-use hazard detection and ID/EX register.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter logic [15:0] StallCountMax = 16'hFFFF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [DW-1:0] i_instr,
  input  logic          i_instr_valid,
  input  logic          i_flush,
  output logic [RW-1:0] o_read1,
  output logic [RW-1:0] o_read2,
  input  logic [DW-1:0] i_data1,
  input  logic [DW-1:0] i_data2,
  input  logic          i_wb_reg_write,
  input  logic [RW-1:0] i_wb_write_reg,
  input  logic [DW-1:0] i_wb_write_data,
  output logic          o_stall,
  output logic          o_ex_valid,
  output logic [DW-1:0] o_ex_a,
  output logic [DW-1:0] o_ex_b,
  output logic [DW-1:0] o_ex_imm,
  output logic [RW-1:0] o_ex_rs,
  output logic [RW-1:0] o_ex_rt,
  output logic [RW-1:0] o_ex_dest,
  output logic          o_ex_reg_write,
  output logic          o_ex_mem_read,
  output logic          o_ex_mem_write,
  output logic [5:0]    o_ex_opcode,
  output logic [5:0]    o_ex_funct,
  output logic [15:0]   o_stall_count
);

  logic [RW-1:0] w_rs, w_rt, w_dest;
  logic [DW-1:0] w_imm, w_op_a, w_op_b;
  logic          w_reg_write, w_mem_read, w_mem_write, w_hazard, w_wb_hit;

  logic          r_valid;
  ex_ctrl_t      r_ctrl;
  logic [DW-1:0] r_a, r_b, r_imm;
  logic [RW-1:0] r_rs, r_rt, r_dest;
  logic [5:0]    r_opcode, r_funct;
  logic [15:0]   r_count;

  assign w_rs    = i_instr[25:21];
  assign w_rt    = i_instr[20:16];
  assign o_read1 = w_rs;
  assign o_read2 = w_rt;

  id_decode u_decode (
    .i_instr     (i_instr),
    .o_reg_write (w_reg_write),
    .o_mem_read  (w_mem_read),
    .o_mem_write (w_mem_write),
    .o_dest      (w_dest),
    .o_imm       (w_imm)
  );

  // Same-edge write-back bypass and conservative load-use hazard check.
  always_comb begin
    w_wb_hit = i_wb_reg_write && (i_wb_write_reg != '0);
    w_op_a   = (w_wb_hit && i_wb_write_reg == w_rs) ? i_wb_write_data : i_data1;
    w_op_b   = (w_wb_hit && i_wb_write_reg == w_rt) ? i_wb_write_data : i_data2;
    w_hazard = r_valid && r_ctrl.mem_read && (r_dest != '0) && i_instr_valid &&
               ((w_rs == r_dest) || (w_rt == r_dest));
    o_stall  = w_hazard && !i_flush;
  end

  // ID/EX register: bubbles clear only the valid/control/dest fields.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_dest   <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
    end else if (i_flush || w_hazard || !i_instr_valid) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_dest  <= '0;
    end else begin
      r_valid  <= 1'b1;
      r_ctrl   <= '{reg_write: w_reg_write, mem_read: w_mem_read, mem_write: w_mem_write};
      r_a      <= w_op_a;
      r_b      <= w_op_b;
      r_imm    <= w_imm;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_dest   <= w_dest;
      r_opcode <= i_instr[31:26];
      r_funct  <= i_instr[5:0];
    end
  end

  // Saturating count of inserted load-use bubbles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (o_stall && (r_count != StallCountMax)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_ex_valid     = r_valid;
  assign o_ex_reg_write = r_ctrl.reg_write;
  assign o_ex_mem_read  = r_ctrl.mem_read;
  assign o_ex_mem_write = r_ctrl.mem_write;
  assign o_ex_a         = r_a;
  assign o_ex_b         = r_b;
  assign o_ex_imm       = r_imm;
  assign o_ex_rs        = r_rs;
  assign o_ex_rt        = r_rt;
  assign o_ex_dest      = r_dest;
  assign o_ex_opcode    = r_opcode;
  assign o_ex_funct     = r_funct;
  assign o_stall_count  = r_count;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register for the pipelined MIPS datapath. It sits directly downstream of the 32x32 register file. It drives the file's read addresses from the IF/ID instruction and captures the returned operands, with write-back bypass and light decode, into the EX-stage register. It also detects load-use hazards, inserting a one-cycle bubble and stalling fetch, and honours branch flushes.

## Interface
- DW, 32, datapath width
- RW, 5, register-number width
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; clears all state
- Instr  in  DW  IF/ID instruction
- InstrValid  in  1  Instr holds a real instruction
- Flush  in  1  squash the instruction currently in ID (taken branch/jump)
- Read1  out  RW  Instr[25:21] (rs), combinational, to register file
- Read2  out  RW  Instr[20:16] (rt), combinational, to register file
- Data1, Data2  in  DW  register file read data
- WB_RegWrite  in  1  same signal as the register file write enable
- WB_WriteReg  in  RW  same as register file write address
- WB_WriteData  in  DW  same as register file write data
- Stall  out  1  hold PC and IF/ID this cycle (combinational)
- EX_Valid  out  1  EX register holds a real instruction
- EX_A, EX_B  out  DW  rs / rt operand values
- EX_Imm  out  DW  extended immediate
- EX_Rs, EX_Rt  out  RW  source numbers, for EX forwarding
- EX_Dest  out  RW  destination register
- EX_RegWrite, EX_MemRead, EX_MemWrite  out  1  control bits
- EX_Opcode  out  6  Instr[31:26]
- EX_Funct  out  6  Instr[5:0]
- StallCount  out  16  saturating count of inserted load-use bubbles

## Operation
- Decode (opcode = Instr[31:26]):
  - 0x00 R-type: RegWrite=1, Dest=rd (Instr[15:11]).
  - 0x08 addi, 0x0A slti, 0x0F lui: RegWrite=1, Dest=rt.
  - 0x0C andi, 0x0D ori: RegWrite=1, Dest=rt.
  - 0x23 lw: RegWrite=1, MemRead=1, Dest=rt.
  - 0x2B sw: MemWrite=1.
  - 0x04 beq, 0x05 bne, all other opcodes: all control bits 0.
  - Dest=0 forces RegWrite=0.
- Immediate: zero-extended for andi/ori; sign-extended from Instr[15:0] otherwise.
- Bypass: the register file writes on the same edge that captures, so combinational reads return the stale value.
  - EX_A captures WB_WriteData when WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg==rs; otherwise Data1.
  - Same rule for EX_B/rt against Data2.
  - Register 0 is never bypassed.
- Hazard = EX_Valid & EX_MemRead & EX_Dest!=0 & InstrValid & (rs==EX_Dest | rt==EX_Dest).
  - Compare rt for every opcode; the check is deliberately conservative.
  - Stall = Hazard & ~Flush.
- Capture each edge, in priority order:
  - reset: zero everything.
  - else Flush, Hazard, or ~InstrValid: load a bubble.
  - else: load the decoded instruction with EX_Valid=1.
- Bubble: EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite and EX_Dest are 0; data fields hold their previous values.
- StallCount increments on every edge where Stall=1 and saturates at 0xFFFF.

## Timing
- Latency: one cycle, ID inputs to EX outputs.
- Read1/Read2/Stall are combinational and have no reset dependence.
- Reset values: all registered outputs are 0, including StallCount and EX_Valid.
- Load-use: the stall lasts exactly one cycle. The bubble clears EX_MemRead, so Stall deasserts the next cycle while Instr is unchanged, and the instruction then captures normally.
- Back-to-back loads with chained dependences give one bubble per pair.
- Flush coincident with a hazard: bubble, Stall=0, StallCount unchanged.
- Reset during a stall: bubble state cleared and StallCount=0. Stall may be high on the reset edge, but the count does not increment.
- A write-back to the same register as both rs and rt bypasses both operands.

## Structure
- The shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE)
  - DW/RW defaults
  - the EX control bundle type
- One combinational sub-module, id_decode: Instr in; RegWrite, MemRead, MemWrite, Dest, Imm out.
- Bypass, hazard logic, pipeline register and counter live in id_ex_stage.

## Test plan
- Reset asserted 2 cycles, then Instr=addi $9,$0,5 (0x20090005) -> after one edge EX_Valid=1, EX_Dest=9, EX_Imm=0x00000005, EX_RegWrite=1; while reset=1 all outputs 0.
- Data1=0x11, WB_RegWrite=1, WB_WriteReg=rs=8, WB_WriteData=0xAA -> EX_A=0xAA. Repeat with WB_WriteReg=0 and rs=0 -> EX_A=Data1.
- lw $8,0($4) captured, then add $10,$8,$9 in ID -> Stall=1 one cycle, bubble with EX_Valid=0, StallCount=1; next edge captures add with EX_Valid=1.
- Same load-use setup with Flush=1 -> Stall=0, bubble, StallCount=0.
- andi $3,$2,0x8000 -> EX_Imm=0x00008000; addi $3,$2,-1 (imm 0xFFFF) -> EX_Imm=0xFFFFFFFF.
- Force 65,540 load-use stalls -> StallCount=0xFFFF, holds; R-type with rd=0 -> EX_RegWrite=0.
